pwm_multi_generator: RTL and testbench
======================================

Name: pwm_multi_generator

Overview:
Parametrised multi-channel successor to the single-channel 8-bit PWM generator. It drives CHANNELS PWM outputs from one shared period counter. It adds a programmable clock prescaler, edge- or center-aligned counting, per-channel output polarity and double-buffered (shadow) duty registers. Duty updates take effect only at period boundaries, so outputs never glitch. It sits between the control/register logic and the motor/LED drive pins, clocked at 50 MHz.

Parameters:
CHANNELS, 4, number of PWM outputs
WIDTH, 8, counter and duty resolution in bits; M = 2^WIDTH-1
PRESC_W, 16, prescaler width

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-low (0 = reset)
en  in  1  global enable
mode  in  1  0 = edge-aligned, 1 = center-aligned
prescale  in  PRESC_W  counter advances every prescale+1 clk cycles
duty  in  CHANNELS*WIDTH  channel i duty on bits [i*WIDTH +: WIDTH]
duty_wr  in  CHANNELS  per-channel strobe; captures that channel's duty into its shadow register
polarity  in  CHANNELS  1 = output inverted (active-low drive)
period_start  out  1  one-cycle pulse at each period boundary
pwm_out  out  CHANNELS  PWM outputs, registered

Behaviour:
- Reset (rst=0, async): prescaler, counter, direction, shadow and active duties, active mode and active prescale all 0. pwm_out=0 and period_start=0 immediately.
- Prescaler: counts 0..active_prescale; tick asserts when prescaler == active_prescale, then prescaler wraps to 0. With prescale=0, tick is asserted every cycle.
- Edge mode: the counter advances on each tick as 0,1,...,M,0. A boundary is the tick at cnt==M. Period = 2^WIDTH*(P+1) clk.
- Center mode: the counter runs 0 up to M, then down to 0; the direction reverses at M and at 0. A boundary is the tick at cnt==1 while counting down. Period = 2M*(P+1) clk.
- Shadow registers: duty_wr[i]=1 loads the shadow for channel i on that clk edge, at any time and in any state.
- Boundary load: at each boundary, active_duty[i] <= shadow[i] (or the duty input if duty_wr[i] is asserted in the same cycle; the write wins). mode and prescale are also sampled into their active registers at the boundary.
- period_start: asserted for one clk in the cycle the counter holds 0 at the start of a period.
- Compare: raw[i] = (cnt < active_duty[i]). pwm_out[i] <= raw[i] XOR polarity[i], registered, so pwm_out lags the counter by 1 clk.
- Resulting high time (polarity=0): edge mode gives duty*(P+1) clk; duty=0 gives constant low; duty=M gives M/2^WIDTH. Center mode gives (2*duty-1)*(P+1) clk for duty>=1, centered on cnt=0, and 0 for duty=0.
- en=0:
  - prescaler and counter are held at 0 and direction is set to up.
  - active registers follow shadow/mode/prescale every cycle.
  - pwm_out <= polarity, i.e. the idle inactive level.
  - period_start stays 0.
- en rising: the first enabled cycle has cnt=0, period_start=1 and uses the latest shadow values. en falling mid-period: idle level on the next edge, and the counter is cleared.
- Reset released mid-operation: restarts as from power-up. pwm_out leaves 0 only after the first clk edge (idle = polarity).
- Counter, prescaler and all arithmetic are unsigned. There is no overflow beyond the wrap rules above. A mode change mid-period is deferred to the boundary.

Test Plan:
1. WIDTH=8, P=0, edge mode, duty0=64, en=1 -> pwm_out[0] high 64 of every 256 clk (195.3 kHz); period_start pulses every 256 clk.
2. Duty0=64 running; write duty_wr[0] with 128 at cnt=100 -> the current period stays 64 high; the next period, starting at the period_start pulse, is 128 high.
3. Center mode, P=0, duty1=64 -> high 127 of every 510 clk, symmetric about cnt=0. Duty1=0 -> constant low. Edge mode duty2=255 -> high 255/256.
4. prescale=3, edge mode, duty=192 -> period 1024 clk, high 768 clk. Change prescale to 0 mid-period -> takes effect only after the next boundary.
5. polarity=4'b1010 with en=0 -> pwm_out=4'b1010. en=1, all duties 64 -> channels 1 and 3 low for 64 clk, high for 192 clk.
6. Assert rst=0 mid-period -> pwm_out=0 and period_start=0 without waiting for a clk edge. Release with en=1 -> counting restarts at 0 with all duties 0 until rewritten.

Source files
------------

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator sharing one prescaled period counter.
// Edge/center-aligned counting, per-channel polarity, shadowed duty registers loaded at period boundaries.
module pwm_multi_generator #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       duty_wr,
  input  logic [CHANNELS-1:0]       polarity,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pwm_out
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0]   CNT_MAX    = '1;
  localparam logic [WIDTH-1:0]   CNT_ONE    = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] active_presc;
  logic [WIDTH-1:0]   cnt;
  dir_t               dir;
  logic               active_mode;
  logic [WIDTH-1:0]   shadow      [CHANNELS];
  logic [WIDTH-1:0]   active_duty [CHANNELS];
  logic [WIDTH-1:0]   shadow_next [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic               tick;
  logic               boundary;

  // A same-cycle duty write bypasses the shadow so it is never lost at a boundary.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_next[i] = duty_wr[i] ? duty[i*WIDTH +: WIDTH] : shadow[i];
      raw[i]         = (cnt < active_duty[i]);
    end
  end

  assign tick     = (presc_cnt == active_presc);
  assign boundary = tick && (active_mode ? ((dir == DIR_DOWN) && (cnt == CNT_ONE))
                                         : (cnt == CNT_MAX));

  // Counter sits at 0 exactly once per period, on its first prescaler phase.
  assign period_start = rst & en & (cnt == '0) & (presc_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt    <= '0;
      active_presc <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      active_mode  <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i]      <= '0;
        active_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= shadow_next[i];
      end
      if (!en) begin
        presc_cnt    <= '0;
        cnt          <= '0;
        dir          <= DIR_UP;
        active_mode  <= mode;
        active_presc <= prescale;
        pwm_out      <= polarity;
        for (int i = 0; i < CHANNELS; i++) begin
          active_duty[i] <= shadow_next[i];
        end
      end else begin
        pwm_out <= raw ^ polarity;
        if (!tick) begin
          presc_cnt <= presc_cnt + PRESC_ONE;
        end else begin
          presc_cnt <= '0;
          // Mode, prescale and duties only change here, so a period is never cut short.
          if (boundary) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            active_mode  <= mode;
            active_presc <= prescale;
            for (int i = 0; i < CHANNELS; i++) begin
              active_duty[i] <= shadow_next[i];
            end
          end else if (!active_mode) begin
            cnt <= cnt + CNT_ONE;
          end else if (dir == DIR_UP) begin
            if (cnt == CNT_MAX) begin
              cnt <= cnt - CNT_ONE;
              dir <= DIR_DOWN;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Bench for pwm_multi_generator: period-position reference model checked every cycle,
// directed scenarios with hand-computed counts, then randomized stimulus.
module tb_pwm_multi_generator;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 16;
  localparam int M  = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            mode = 1'b0;
  logic [PW-1:0]   prescale = '0;
  logic [CH*W-1:0] duty = '0;
  logic [CH-1:0]   duty_wr = '0;
  logic [CH-1:0]   polarity = '0;
  logic            period_start;
  logic [CH-1:0]   pwm_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Model state: position in period (ticks), clocks within current tick, active settings.
  int            m_k, m_sub, m_presc;
  bit            m_mode;
  int            m_act    [CH];
  int            m_shadow [CH];
  int            sh_new   [CH];
  logic [CH-1:0] m_pwm;

  pwm_multi_generator #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .prescale(prescale),
    .duty(duty), .duty_wr(duty_wr), .polarity(polarity),
    .period_start(period_start), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  function automatic int cnt_of(input int k, input bit md);
    if (!md) return k;
    return (k <= M) ? k : 2 * M - k;
  endfunction

  function automatic int period_len(input bit md);
    return md ? 2 * M : M + 1;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_k = 0; m_sub = 0; m_presc = 0; m_mode = 1'b0; m_pwm = '0;
        for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_shadow[i] = 0; end
      end else begin
        for (int i = 0; i < CH; i++)
          sh_new[i] = duty_wr[i] ? int'(duty[i*W +: W]) : m_shadow[i];
        if (!en) begin
          m_k = 0; m_sub = 0;
          m_mode = mode; m_presc = int'(prescale);
          m_pwm = polarity;
          for (int i = 0; i < CH; i++) m_act[i] = sh_new[i];
        end else begin
          for (int i = 0; i < CH; i++)
            m_pwm[i] = (cnt_of(m_k, m_mode) < m_act[i]) ^ polarity[i];
          if (m_sub == m_presc) begin
            m_sub = 0;
            m_k++;
            if (m_k == period_len(m_mode)) begin
              m_k = 0;
              m_mode = mode; m_presc = int'(prescale);
              for (int i = 0; i < CH; i++) m_act[i] = sh_new[i];
            end
          end else begin
            m_sub++;
          end
        end
        for (int i = 0; i < CH; i++) m_shadow[i] = sh_new[i];
      end
    end
  end

  // Every-cycle comparison against the model, one time unit after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (checking) begin
        check("pwm_out", pwm_out, m_pwm);
        check("period_start", period_start, rst && en && m_k == 0 && m_sub == 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_duty(input int ch, input int val);
    duty[ch*W +: W] = W'(val);
    duty_wr[ch] = 1'b1;
    step();
    duty_wr[ch] = 1'b0;
  endtask

  task automatic wait_ps(input int limit, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!period_start && cycles < limit);
    if (!period_start) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL wait_period_start at %0t: got timeout after %0d, expected pulse", $time, cycles);
    end
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = int'(pwm_out[ch]);
    for (int j = 1; j < n; j++) begin
      step();
      hi += int'(pwm_out[ch]);
    end
  endtask

  task automatic apply_stimulus();
    int r;
    duty_wr = '0;
    if ($urandom_range(0, 999) < 60) begin
      for (int i = 0; i < CH; i++) begin
        r = $urandom_range(0, 3);
        duty[i*W +: W] = (r == 0) ? '0 : (r == 1) ? W'(M) : W'($urandom_range(0, M));
      end
      duty_wr = CH'($urandom_range(1, (1 << CH) - 1));
    end
    if ($urandom_range(0, 399) == 0) en = ~en;
    if ($urandom_range(0, 199) == 0) mode = $urandom_range(0, 1) != 0;
    if ($urandom_range(0, 199) == 0) prescale = PW'($urandom_range(0, 2));
    if ($urandom_range(0, 299) == 0) polarity = CH'($urandom_range(0, (1 << CH) - 1));
    if ($urandom_range(0, 4999) == 0) begin
      rst = 1'b0;
      step();
      rst = 1'b1;
    end
  endtask

  initial begin
    int c, hi;
    #3;
    rst = 1'b0;
    checking = 1'b1;
    #1;
    check("reset_pwm_out", pwm_out, 0);
    check("reset_period_start", period_start, 0);
    step();
    rst = 1'b1;
    step();

    // Edge mode, P=0, duty0=64
    set_duty(0, 64);
    en = 1'b1;
    #1;
    check("en_rise_period_start", period_start, 1);
    step();
    wait_ps(600, c);
    wait_ps(600, c);
    check("edge_period_len", c, 256);
    count_high(0, 256, hi);
    check("edge_high_64", hi, 64);

    // Mid-period duty write takes effect next period
    wait_ps(600, c);
    hi = int'(pwm_out[0]);
    for (int j = 1; j < 256; j++) begin
      if (j == 100) begin duty[0 +: W] = 8'd128; duty_wr[0] = 1'b1; end
      if (j == 101) duty_wr[0] = 1'b0;
      step();
      hi += int'(pwm_out[0]);
    end
    check("deferred_duty_old", hi, 64);
    wait_ps(600, c);
    check("deferred_next_ps", c, 1);
    count_high(0, 256, hi);
    check("deferred_duty_new", hi, 128);

    // Center mode, P=0
    en = 1'b0;
    mode = 1'b1;
    set_duty(1, 64);
    en = 1'b1;
    step();
    wait_ps(1200, c);
    wait_ps(1200, c);
    check("center_period_len", c, 510);
    count_high(1, 510, hi);
    check("center_high_64", hi, 127);
    set_duty(1, 0);
    wait_ps(1200, c);
    count_high(1, 510, hi);
    check("center_high_0", hi, 0);
    mode = 1'b0;
    set_duty(2, 255);
    wait_ps(1200, c);
    wait_ps(1200, c);
    check("edge_after_center_len", c, 256);
    count_high(2, 256, hi);
    check("edge_high_255", hi, 255);

    // Prescale 3, duty 192, then deferred prescale change
    en = 1'b0;
    prescale = 16'd3;
    set_duty(0, 192);
    en = 1'b1;
    step();
    wait_ps(2100, c);
    wait_ps(2100, c);
    check("presc3_period_len", c, 1024);
    count_high(0, 1024, hi);
    check("presc3_high", hi, 768);
    wait_ps(2100, c);
    repeat (100) step();
    prescale = 16'd0;
    wait_ps(2100, c);
    check("presc_change_deferred", c, 924);
    wait_ps(2100, c);
    check("presc0_period_len", c, 256);

    // Polarity idle level and inverted channels
    en = 1'b0;
    polarity = 4'b1010;
    duty = {4{8'd64}};
    duty_wr = 4'b1111;
    step();
    duty_wr = '0;
    step();
    check("idle_polarity", pwm_out, 4'b1010);
    en = 1'b1;
    step();
    wait_ps(600, c);
    count_high(1, 256, hi);
    check("inverted_ch1_high", hi, 192);
    wait_ps(600, c);
    count_high(0, 256, hi);
    check("normal_ch0_high", hi, 64);

    // Asynchronous reset mid-period
    repeat (77) step();
    rst = 1'b0;
    #1;
    check("async_reset_pwm", pwm_out, 0);
    check("async_reset_ps", period_start, 0);
    step();
    rst = 1'b1;
    #1;
    check("reset_release_ps", period_start, 1);
    step();
    check("reset_release_idle", pwm_out, 4'b1010);
    wait_ps(600, c);
    check("reset_release_period", c, 255);

    // Randomized phase
    for (int n = 0; n < 20000; n++) begin
      apply_stimulus();
      step();
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
